// File: rtl/pi_leaf_port.sv
// pi_leaf_port: leaf network interface with TX/RX FIFOs decoupling a PE from a non-backpressuring switch port.
module pi_leaf_port #(
  parameter int num_leaves = 2,
  parameter int payload_sz = 1,
  parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int leaf_addr  = 0,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_sz-1:0]               bus_i,
  output logic [p_sz-1:0]               bus_o,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [$clog2(num_leaves)-1:0] tx_dest,
  input  logic [payload_sz-1:0]         tx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [payload_sz-1:0]         rx_data,
  output logic [15:0]                   rx_drop_cnt,
  output logic                          misroute
);
  localparam int addr_w = $clog2(num_leaves);
  localparam int pw     = $clog2(fifo_depth);
  localparam int tw     = addr_w + payload_sz;
  logic [tw-1:0]         r_tx_mem [fifo_depth];
  logic [payload_sz-1:0] r_rx_mem [fifo_depth];
  logic [pw-1:0]         r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [pw:0]           r_tx_cnt, r_rx_cnt;
  logic [p_sz-1:0]       r_bus;
  logic [15:0]           r_drop;
  logic                  r_mis;
  logic                  w_tx_push, w_tx_pop, w_rx_v, w_rx_hit, w_rx_full, w_rx_pop, w_rx_push, w_rx_drop;
  assign tx_ready    = r_tx_cnt != (pw+1)'(fifo_depth);
  assign w_tx_push   = tx_valid & tx_ready;
  assign w_tx_pop    = r_tx_cnt != '0;
  assign w_rx_v      = bus_i[p_sz-1];
  assign w_rx_hit    = bus_i[p_sz-2 -: addr_w] == addr_w'(leaf_addr);
  assign w_rx_full   = r_rx_cnt == (pw+1)'(fifo_depth);
  assign rx_valid    = r_rx_cnt != '0;
  assign rx_data     = r_rx_mem[r_rx_rp];
  assign w_rx_pop    = rx_valid & rx_ready;
  assign w_rx_push   = w_rx_v & w_rx_hit & (!w_rx_full | w_rx_pop);
  assign w_rx_drop   = w_rx_v & w_rx_hit & w_rx_full & !w_rx_pop;
  assign bus_o       = r_bus;
  assign rx_drop_cnt = r_drop;
  assign misroute    = r_mis;
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= {tx_dest, tx_data};
    if (w_rx_push) r_rx_mem[r_rx_wp] <= bus_i[payload_sz-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_bus    <= '0;
      r_drop   <= '0;
      r_mis    <= 1'b0;
    end else begin
      r_tx_wp  <= r_tx_wp + pw'(w_tx_push);
      r_tx_rp  <= r_tx_rp + pw'(w_tx_pop);
      r_tx_cnt <= r_tx_cnt + (pw+1)'(w_tx_push) - (pw+1)'(w_tx_pop);
      r_bus    <= w_tx_pop ? {1'b1, r_tx_mem[r_tx_rp]} : '0;
      r_rx_wp  <= r_rx_wp + pw'(w_rx_push);
      r_rx_rp  <= r_rx_rp + pw'(w_rx_pop);
      r_rx_cnt <= r_rx_cnt + (pw+1)'(w_rx_push) - (pw+1)'(w_rx_pop);
      if (w_rx_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (w_rx_v && !w_rx_hit) r_mis <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pi_leaf_port.sv
// tb_pi_leaf_port: directed and randomized checks of pi_leaf_port against a queue-based packet model.
module tb_pi_leaf_port;
  localparam int NL = 4, PL = 8, LA = 2, D = 4, AW = 2, PS = 1 + AW + PL;
  logic          clk = 1'b0, reset;
  logic [PS-1:0] bus_i, bus_o;
  logic          tx_valid, tx_ready, rx_valid, rx_ready, misroute;
  logic [AW-1:0] tx_dest;
  logic [PL-1:0] tx_data, rx_data;
  logic [15:0]   rx_drop_cnt;
  int            vectors = 0, errors = 0;
  logic [AW+PL-1:0] tq[$];
  logic [PL-1:0]    rq[$];
  logic [PS-1:0]    m_bus;
  int               m_drop;
  logic             m_mis;
  pi_leaf_port #(.num_leaves(NL), .payload_sz(PL), .leaf_addr(LA), .fifo_depth(D)) dut (
    .clk(clk), .reset(reset), .bus_i(bus_i), .bus_o(bus_o),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_drop_cnt(rx_drop_cnt), .misroute(misroute)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic compare();
    chk("bus_o", 32'(bus_o), 32'(m_bus));
    chk("tx_ready", 32'(tx_ready), 32'(tq.size() < D));
    chk("rx_valid", 32'(rx_valid), 32'(rq.size() > 0));
    if (rq.size() > 0) chk("rx_data", 32'(rx_data), 32'(rq[0]));
    chk("rx_drop_cnt", 32'(rx_drop_cnt), 32'(m_drop));
    chk("misroute", 32'(misroute), 32'(m_mis));
  endtask
  task automatic model_clear();
    tq.delete();
    rq.delete();
    m_bus  = '0;
    m_drop = 0;
    m_mis  = 1'b0;
  endtask
  task automatic step();
    bit acc;
    logic [PL-1:0] junk;
    acc = tx_valid && tq.size() < D;
    m_bus = '0;
    if (tq.size() > 0) m_bus = {1'b1, tq.pop_front()};
    if (acc) tq.push_back({tx_dest, tx_data});
    if (rx_ready && rq.size() > 0) junk = rq.pop_front();
    if (bus_i[PS-1]) begin
      if (bus_i[PS-2 -: AW] == AW'(LA)) begin
        if (rq.size() < D) rq.push_back(bus_i[PL-1:0]);
        else if (m_drop < 65535) m_drop++;
      end else m_mis = 1'b1;
    end
    @(posedge clk);
    #1;
    compare();
  endtask
  task automatic idle();
    tx_valid = 1'b0;
    tx_dest  = '0;
    tx_data  = '0;
    bus_i    = '0;
    rx_ready = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    compare();
    tx_valid = 1'b1; tx_dest = 2'd1; tx_data = 8'hA5;
    step();
    chk("t1_no_bypass", 32'(bus_o), 32'd0);
    tx_valid = 1'b0;
    step();
    chk("t1_bus", 32'(bus_o), 32'({1'b1, 2'd1, 8'hA5}));
    step();
    chk("t1_idle", 32'(bus_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_dest = AW'(i); tx_data = 8'h10 + 8'(i);
      step();
      chk("t2_ready", 32'(tx_ready), 32'd1);
    end
    tx_valid = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      bus_i = {1'b1, AW'(LA), 8'h30 + 8'(i)};
      step();
    end
    chk("t3_head", 32'(rx_data), 32'h30);
    bus_i = {1'b1, AW'(LA), 8'h34};
    step();
    chk("t3_drop", 32'(rx_drop_cnt), 32'd1);
    bus_i = '0;
    step();
    chk("t3_hold", 32'(rx_data), 32'h30);
    rx_ready = 1'b1;
    bus_i = {1'b1, AW'(LA), 8'h40};
    step();
    chk("t4_no_drop", 32'(rx_drop_cnt), 32'd1);
    chk("t4_head", 32'(rx_data), 32'h31);
    bus_i = '0;
    repeat (5) step();
    rx_ready = 1'b0;
    bus_i = {1'b1, AW'(LA), 8'h55};
    step();
    bus_i = {1'b1, 2'd3, 8'h66};
    step();
    chk("t5_mis", 32'(misroute), 32'd1);
    bus_i = '0;
    tx_valid = 1'b1; tx_dest = 2'd3; tx_data = 8'h77;
    step();
    tx_valid = 1'b0;
    step();
    chk("t5_bus_busy", 32'(bus_o), 32'({1'b1, 2'd3, 8'h77}));
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk("t5_rst_mis", 32'(misroute), 32'd0);
    chk("t5_rst_bus", 32'(bus_o), 32'd0);
    chk("t5_rst_rxv", 32'(rx_valid), 32'd0);
    chk("t5_rst_txr", 32'(tx_ready), 32'd1);
    chk("t5_rst_drop", 32'(rx_drop_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    compare();
    for (int n = 0; n < 3000; n++) begin
      tx_valid = ($urandom_range(0, 99) < 55);
      tx_dest  = AW'($urandom);
      tx_data  = PL'($urandom);
      rx_ready = ($urandom_range(0, 99) < 40);
      bus_i    = PS'($urandom);
      bus_i[PS-1] = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 90) bus_i[PS-2 -: AW] = AW'(LA);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
